// File: rtl/fetch_ctrl.sv
// Fetch controller: PC register, ROM select and IF/ID pipeline register.
// Handles stall, delay-slot branches, fetch address errors, exceptions and eret.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h00003000,
  parameter logic [31:0] HANDLER_PC = 32'h00004180,
  parameter logic [31:0] ROM_LAST   = 32'h00006FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] rom_pc,
  output logic        rom_sel,
  input  logic [31:0] rom_d,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic        adel_D,
  output logic        in_handler
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  state_e      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_n, pcd_n;
  logic        adel_n, inh_n;
  logic        legal, exc_ok;

  assign legal   = (pc[1:0] == 2'b00) && (pc >= RESET_PC) && (pc <= ROM_LAST);
  assign rom_sel = legal && (state == RUN);
  assign rom_pc  = pc;
  assign exc_ok  = exc_req && !in_handler;

  // State, PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      pc         <= RESET_PC;
      instr_D    <= 32'h0;
      pc_D       <= 32'h0;
      adel_D     <= 1'b0;
      in_handler <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      instr_D    <= instr_n;
      pc_D       <= pcd_n;
      adel_D     <= adel_n;
      in_handler <= inh_n;
    end
  end

  // Next-state selection in priority order: exc, eret, stall, fault, fetch
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr_D;
    pcd_n   = pc_D;
    adel_n  = adel_D;
    inh_n   = in_handler;
    if (exc_ok) begin
      pc_n    = HANDLER_PC;
      instr_n = 32'h0;
      pcd_n   = 32'h0;
      adel_n  = 1'b0;
      state_n = RUN;
      inh_n   = 1'b1;
    end else if (eret) begin
      pc_n    = epc;
      instr_n = 32'h0;
      pcd_n   = 32'h0;
      adel_n  = 1'b0;
      state_n = RUN;
      inh_n   = 1'b0;
    end else if (stall) begin
      pc_n = pc;
    end else if (state == FAULT) begin
      // Error already reported once; keep feeding bubbles
      instr_n = 32'h0;
      pcd_n   = 32'h0;
      adel_n  = 1'b0;
    end else if (!legal) begin
      instr_n = 32'h0;
      pcd_n   = pc;
      adel_n  = 1'b1;
      state_n = FAULT;
    end else begin
      instr_n = rom_d;
      pcd_n   = pc;
      adel_n  = 1'b0;
      pc_n    = br_take ? br_target : pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected outputs are queued per step
// and popped for comparison one cycle later.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, br_take, exc_req, eret;
  logic [31:0] br_target, epc;
  logic [31:0] rom_pc, rom_d, instr_D, pc_D;
  logic        rom_sel, adel_D, in_handler;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic        adel;
    logic        inh;
    logic        sel;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_take(br_take), .br_target(br_target),
    .exc_req(exc_req), .eret(eret), .epc(epc),
    .rom_pc(rom_pc), .rom_sel(rom_sel), .rom_d(rom_d),
    .instr_D(instr_D), .pc_D(pc_D), .adel_D(adel_D),
    .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] idx;
    if (a >= 32'h3000 && a < 32'h3010) begin
      idx = ((a - 32'h3000) >> 2) + 32'd1;
      return 32'h11111111 * idx;
    end
    return {16'hC0DE, a[15:0]};
  endfunction

  // Combinational instruction ROM
  always_comb rom_d = rom(rom_pc);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [31:0] bt, input logic x,
                       input logic e, input logic [31:0] ep);
    reset = r; stall = s; br_take = b; br_target = bt;
    exc_req = x; eret = e; epc = ep;
  endtask

  // Push expectation, clock once, pop and compare
  task automatic step(input string tag, input logic [31:0] p,
                      input logic [31:0] i, input logic [31:0] d,
                      input logic a, input logic h, input logic s);
    exp_t e;
    sbq.push_back('{p, i, d, a, h, s});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".rom_pc"}, rom_pc, e.pc);
    chk({tag, ".instr_D"}, instr_D, e.instr);
    chk({tag, ".pc_D"}, pc_D, e.pcd);
    chk({tag, ".adel_D"}, {31'h0, adel_D}, {31'h0, e.adel});
    chk({tag, ".in_handler"}, {31'h0, in_handler}, {31'h0, e.inh});
    chk({tag, ".rom_sel"}, {31'h0, rom_sel}, {31'h0, e.sel});
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 1, 1, 32'h5000, 0, 0, 0);
    step("reset", 32'h3000, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("seq0", 32'h3004, 32'h11111111, 32'h3000, 0, 0, 1);
    step("seq1", 32'h3008, 32'h22222222, 32'h3004, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 0);
    step("stall0", 32'h3008, 32'h22222222, 32'h3004, 0, 0, 1);
    step("stall1", 32'h3008, 32'h22222222, 32'h3004, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("resume", 32'h300C, 32'h33333333, 32'h3008, 0, 0, 1);
    drive(0, 0, 1, 32'h3100, 0, 0, 0);
    step("br_dslot", 32'h3100, 32'h44444444, 32'h300C, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("br_tgt", 32'h3104, rom(32'h3100), 32'h3100, 0, 0, 1);
    drive(0, 0, 1, 32'h3002, 0, 0, 0);
    step("br_bad", 32'h3002, rom(32'h3104), 32'h3104, 0, 0, 0);
    drive(0, 0, 1, 32'h3200, 0, 0, 0);
    step("adel", 32'h3002, 0, 32'h3002, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("fault_bub", 32'h3002, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    step("fault_stall", 32'h3002, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 32'h3200, 1, 0, 0);
    step("exc", 32'h4180, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("hdl_run", 32'h4184, rom(32'h4180), 32'h4180, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    step("exc_ign", 32'h4188, rom(32'h4184), 32'h4184, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 1, 32'h3010);
    step("eret", 32'h3010, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("ret_run", 32'h3014, rom(32'h3010), 32'h3010, 0, 0, 1);
    drive(0, 0, 1, 32'h6FF8, 0, 0, 0);
    step("br_end", 32'h6FF8, rom(32'h3014), 32'h3014, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("last", 32'h6FFC, rom(32'h6FF8), 32'h6FF8, 0, 0, 1);
    step("past", 32'h7000, rom(32'h6FFC), 32'h6FFC, 0, 0, 0);
    step("past_adel", 32'h7000, 0, 32'h7000, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h3000);
    step("exc_vs_eret", 32'h4180, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("hdl2", 32'h4184, rom(32'h4180), 32'h4180, 0, 1, 1);
    drive(1, 1, 0, 0, 0, 0, 0);
    step("reset_mid", 32'h3000, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("post_reset", 32'h3004, 32'h11111111, 32'h3000, 0, 0, 1);
    drive(0, 0, 1, 32'h0FFC, 0, 0, 0);
    step("br_low", 32'h0FFC, 32'h22222222, 32'h3004, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("low_adel", 32'h0FFC, 0, 32'h0FFC, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step("reset_fault", 32'h3000, 0, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
